peio_iobuf: RTL and testbench

- I/O buffer at the far end of the PE load/store interface of an I/O-capable PE.
- Responds to the PE's IOBuf_Pop by supplying PE_Load data from an input FIFO that the host fills.
- Responds to the PE's IOBuf_Push by capturing PE_Store into an output FIFO that the host drains.
- One instance per I/O PE; sits between the PE array and the host/DMA side. Both FIFOs are independent circular buffers with sticky error flags.

---
 rtl/peio_iobuf.sv | 122 ++++++++++++
 tb/tb_peio_iobuf.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/peio_iobuf.sv
// PE-side I/O buffer: host-filled input FIFO feeding PE loads, and a PE-filled output FIFO drained by the host.
// Both FIFOs are wrap-bit circular buffers with sticky error flags; PE pushes pass through a strobe delay line.
module peio_iobuf #(
    parameter int DWIDTH     = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int PUSH_DELAY = 0
) (
    input  logic                  Clk,
    input  logic                  Resetn,
    input  logic                  Clear,
    input  logic                  IOBuf_Pop,
    output logic [DWIDTH-1:0]     PE_Load,
    input  logic                  IOBuf_Push,
    input  logic [DWIDTH-1:0]     PE_Store,
    input  logic                  Host_Wr_En,
    input  logic [DWIDTH-1:0]     Host_Wr_Data,
    input  logic                  Host_Rd_En,
    output logic [DWIDTH-1:0]     Host_Rd_Data,
    output logic [DEPTH_LOG2:0]   In_Count,
    output logic [DEPTH_LOG2:0]   Out_Count,
    output logic                  In_Full,
    output logic                  In_Empty,
    output logic                  Out_Full,
    output logic                  Out_Empty,
    output logic                  Underflow,
    output logic                  Overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [DWIDTH-1:0]   in_mem  [DEPTH];
    logic [DWIDTH-1:0]   out_mem [DEPTH];
    logic [DEPTH_LOG2:0] in_wr_ptr, in_rd_ptr, out_wr_ptr, out_rd_ptr;
    logic                in_wr_ok, in_rd_ok, out_wr_ok, out_rd_ok;
    logic                push_eff;

    // Pointers carry a wrap bit: equal low bits with differing wrap bits means full.
    assign In_Count  = in_wr_ptr - in_rd_ptr;
    assign Out_Count = out_wr_ptr - out_rd_ptr;
    assign In_Empty  = (in_wr_ptr == in_rd_ptr);
    assign Out_Empty = (out_wr_ptr == out_rd_ptr);
    assign In_Full   = (in_wr_ptr[DEPTH_LOG2-1:0] == in_rd_ptr[DEPTH_LOG2-1:0]) &&
                       (in_wr_ptr[DEPTH_LOG2] != in_rd_ptr[DEPTH_LOG2]);
    assign Out_Full  = (out_wr_ptr[DEPTH_LOG2-1:0] == out_rd_ptr[DEPTH_LOG2-1:0]) &&
                       (out_wr_ptr[DEPTH_LOG2] != out_rd_ptr[DEPTH_LOG2]);

    assign in_wr_ok  = Host_Wr_En && !In_Full;
    assign in_rd_ok  = IOBuf_Pop  && !In_Empty;
    assign out_wr_ok = push_eff   && !Out_Full;
    assign out_rd_ok = Host_Rd_En && !Out_Empty;

    generate
        if (PUSH_DELAY == 0) begin : g_nodly
            assign push_eff = IOBuf_Push;
        end else begin : g_dly
            logic [PUSH_DELAY-1:0] push_sr_p0;
            always_ff @(posedge Clk or negedge Resetn) begin
                if (!Resetn) begin
                    push_sr_p0 <= '0;
                end else if (Clear) begin
                    push_sr_p0 <= '0;
                end else begin
                    push_sr_p0 <= PUSH_DELAY'({push_sr_p0, IOBuf_Push});
                end
            end
            assign push_eff = push_sr_p0[PUSH_DELAY-1];
        end
    endgenerate

    // RAM write ports; contents are never reset.
    always_ff @(posedge Clk) begin
        if (in_wr_ok) begin
            in_mem[in_wr_ptr[DEPTH_LOG2-1:0]] <= Host_Wr_Data;
        end
        if (out_wr_ok) begin
            out_mem[out_wr_ptr[DEPTH_LOG2-1:0]] <= PE_Store;
        end
    end

    // Registered read ports, pointers and sticky flags.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            in_wr_ptr    <= '0;
            in_rd_ptr    <= '0;
            out_wr_ptr   <= '0;
            out_rd_ptr   <= '0;
            PE_Load      <= '0;
            Host_Rd_Data <= '0;
            Underflow    <= 1'b0;
            Overflow     <= 1'b0;
        end else if (Clear) begin
            in_wr_ptr    <= '0;
            in_rd_ptr    <= '0;
            out_wr_ptr   <= '0;
            out_rd_ptr   <= '0;
            PE_Load      <= '0;
            Host_Rd_Data <= '0;
            Underflow    <= 1'b0;
            Overflow     <= 1'b0;
        end else begin
            if (in_wr_ok) begin
                in_wr_ptr <= in_wr_ptr + PTR_ONE;
            end
            if (in_rd_ok) begin
                PE_Load   <= in_mem[in_rd_ptr[DEPTH_LOG2-1:0]];
                in_rd_ptr <= in_rd_ptr + PTR_ONE;
            end else if (IOBuf_Pop) begin
                PE_Load   <= '0;
                Underflow <= 1'b1;
            end
            if (out_wr_ok) begin
                out_wr_ptr <= out_wr_ptr + PTR_ONE;
            end else if (push_eff) begin
                Overflow <= 1'b1;
            end
            if (out_rd_ok) begin
                Host_Rd_Data <= out_mem[out_rd_ptr[DEPTH_LOG2-1:0]];
                out_rd_ptr   <= out_rd_ptr + PTR_ONE;
            end
        end
    end
endmodule

// File: tb/tb_peio_iobuf.sv
// Randomized scoreboard bench for peio_iobuf against a queue-based reference model.
module tb_peio_iobuf;
    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int PD    = 2;
    localparam int DEPTH = 1 << AW;

    logic          Clk, Resetn, Clear;
    logic          IOBuf_Pop, IOBuf_Push, Host_Wr_En, Host_Rd_En;
    logic [DW-1:0] PE_Load, PE_Store, Host_Wr_Data, Host_Rd_Data;
    logic [AW:0]   In_Count, Out_Count;
    logic          In_Full, In_Empty, Out_Full, Out_Empty, Underflow, Overflow;

    peio_iobuf #(.DWIDTH(DW), .DEPTH_LOG2(AW), .PUSH_DELAY(PD)) dut (
        .Clk(Clk), .Resetn(Resetn), .Clear(Clear),
        .IOBuf_Pop(IOBuf_Pop), .PE_Load(PE_Load),
        .IOBuf_Push(IOBuf_Push), .PE_Store(PE_Store),
        .Host_Wr_En(Host_Wr_En), .Host_Wr_Data(Host_Wr_Data),
        .Host_Rd_En(Host_Rd_En), .Host_Rd_Data(Host_Rd_Data),
        .In_Count(In_Count), .Out_Count(Out_Count),
        .In_Full(In_Full), .In_Empty(In_Empty),
        .Out_Full(Out_Full), .Out_Empty(Out_Empty),
        .Underflow(Underflow), .Overflow(Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain queues, pending pushes keyed by the cycle they take effect.
    logic [DW-1:0] m_in_q[$], m_out_q[$];
    logic [DW-1:0] sb_load[$], sb_rd[$];
    int            m_pend[$];
    int            cyc;
    logic          m_uf, m_ovf;
    logic [DW-1:0] m_load, m_rd;

    task automatic model_clear();
        m_in_q.delete(); m_out_q.delete(); m_pend.delete();
        sb_load.delete(); sb_rd.delete();
        m_uf = 1'b0; m_ovf = 1'b0; m_load = '0; m_rd = '0;
    endtask

    task automatic model_step();
        int   ic, oc;
        logic pe;
        ic = m_in_q.size();
        oc = m_out_q.size();
        if (IOBuf_Pop) begin
            if (ic > 0) m_load = m_in_q.pop_front();
            else begin m_load = '0; m_uf = 1'b1; end
            sb_load.push_back(m_load);
        end
        if (Host_Wr_En && ic < DEPTH) m_in_q.push_back(Host_Wr_Data);
        if (IOBuf_Push) m_pend.push_back(cyc + PD);
        pe = (m_pend.size() > 0) && (m_pend[0] == cyc);
        if (pe) void'(m_pend.pop_front());
        if (Host_Rd_En) begin
            if (oc > 0) m_rd = m_out_q.pop_front();
            sb_rd.push_back(m_rd);
        end
        if (pe) begin
            if (oc < DEPTH) m_out_q.push_back(PE_Store);
            else m_ovf = 1'b1;
        end
    endtask

    initial begin
        cyc = 0;
        model_clear();
        forever begin
            @(posedge Clk or negedge Resetn);
            if (!Resetn) model_clear();
            else begin
                cyc++;
                if (Clear) model_clear();
                else model_step();
            end
        end
    end

    // Monitor: drains the scoreboard and checks status against the model between edges.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge Clk);
            while (sb_load.size() > 0) begin
                e = sb_load.pop_front();
                chk("pe_load", PE_Load, e);
            end
            while (sb_rd.size() > 0) begin
                e = sb_rd.pop_front();
                chk("host_rd_data", Host_Rd_Data, e);
            end
            chk("pe_load_hold", PE_Load, m_load);
            chk("host_rd_hold", Host_Rd_Data, m_rd);
            chk("in_count", In_Count, m_in_q.size());
            chk("out_count", Out_Count, m_out_q.size());
            chk("in_empty", In_Empty, m_in_q.size() == 0);
            chk("in_full", In_Full, m_in_q.size() == DEPTH);
            chk("out_empty", Out_Empty, m_out_q.size() == 0);
            chk("out_full", Out_Full, m_out_q.size() == DEPTH);
            chk("underflow", Underflow, m_uf);
            chk("overflow", Overflow, m_ovf);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
        IOBuf_Pop = 0; IOBuf_Push = 0; Host_Wr_En = 0; Host_Rd_En = 0; Clear = 0;
        PE_Store = $urandom;
        Host_Wr_Data = $urandom;
    endtask

    initial begin
        Resetn = 0; Clear = 0; IOBuf_Pop = 0; IOBuf_Push = 0;
        Host_Wr_En = 0; Host_Rd_En = 0; PE_Store = '0; Host_Wr_Data = '0;
        repeat (3) tick();
        chk("rst_pe_load", PE_Load, 0);
        chk("rst_in_empty", In_Empty, 1);
        chk("rst_out_empty", Out_Empty, 1);
        Resetn = 1;
        tick();

        // Three host writes then three back-to-back pops
        Host_Wr_En = 1; Host_Wr_Data = 32'h11; tick();
        Host_Wr_En = 1; Host_Wr_Data = 32'h22; tick();
        Host_Wr_En = 1; Host_Wr_Data = 32'h33; tick();
        chk("in_count_3", In_Count, 3);
        IOBuf_Pop = 1; tick();
        chk("load_11", PE_Load, 32'h11);
        IOBuf_Pop = 1; tick();
        chk("load_22", PE_Load, 32'h22);
        IOBuf_Pop = 1; tick();
        chk("load_33", PE_Load, 32'h33);
        chk("in_empty_after", In_Empty, 1);

        // Pop on empty: load zero, sticky underflow, cleared by Clear
        IOBuf_Pop = 1; tick();
        chk("uf_load0", PE_Load, 0);
        chk("uf_set", Underflow, 1);
        repeat (3) tick();
        chk("uf_sticky", Underflow, 1);
        Clear = 1; tick();
        chk("uf_cleared", Underflow, 0);

        // Delayed push: strobe at t, data at t+2, read back at t+5
        IOBuf_Push = 1; tick();
        tick();
        PE_Store = 32'hA5; tick();
        chk("push_count", Out_Count, 1);
        tick(); tick();
        Host_Rd_En = 1; tick();
        chk("push_rd_a5", Host_Rd_Data, 32'hA5);

        // Fill input FIFO, one extra write, drain in order
        for (int i = 0; i <= DEPTH; i++) begin
            Host_Wr_En = 1; Host_Wr_Data = i; tick();
        end
        chk("in_full", In_Full, 1);
        chk("in_count_full", In_Count, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            IOBuf_Pop = 1; tick();
            chk("drain_order", PE_Load, i);
        end
        chk("in_empty_drained", In_Empty, 1);
        // Wrap: concurrent write and pop over another full lap
        Host_Wr_En = 1; tick();
        for (int i = 0; i < DEPTH; i++) begin
            Host_Wr_En = 1; IOBuf_Pop = 1; tick();
        end
        IOBuf_Pop = 1; tick();
        chk("wrap_empty", In_Empty, 1);

        // Output FIFO overflow
        Clear = 1; tick();
        for (int i = 0; i <= DEPTH; i++) begin
            IOBuf_Push = 1; tick();
        end
        repeat (PD + 1) tick();
        chk("ovf_set", Overflow, 1);
        chk("ovf_count", Out_Count, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            Host_Rd_En = 1; tick();
        end
        chk("out_drained", Out_Empty, 1);

        // Random mixed traffic
        Clear = 1; tick();
        for (int i = 0; i < 3000; i++) begin
            IOBuf_Pop  = ($urandom_range(99) < 40);
            Host_Wr_En = ($urandom_range(99) < 50);
            IOBuf_Push = ($urandom_range(99) < 45);
            Host_Rd_En = ($urandom_range(99) < 40);
            Clear      = ($urandom_range(499) == 0);
            @(posedge Clk); #1;
            IOBuf_Pop = 0; IOBuf_Push = 0; Host_Wr_En = 0; Host_Rd_En = 0; Clear = 0;
            PE_Store = $urandom; Host_Wr_Data = $urandom;
        end

        // Asynchronous reset mid-stream with a push in flight
        Clear = 1; tick();
        for (int i = 0; i < 7; i++) begin
            Host_Wr_En = 1; Host_Wr_Data = 32'hC0 + i; tick();
        end
        IOBuf_Pop = 1; tick();
        IOBuf_Pop = 1; tick();
        chk("pre_rst_count", In_Count, 5);
        chk("pre_rst_load", PE_Load, 32'hC1);
        IOBuf_Push = 1; tick();
        Resetn = 0;
        #1;
        chk("async_load0", PE_Load, 0);
        chk("async_in_count", In_Count, 0);
        chk("async_out_count", Out_Count, 0);
        tick(); tick();
        Resetn = 1;
        repeat (5) tick();
        chk("dropped_push", Out_Count, 0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
